// File: rtl/timer_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : timer_seq_master
// Brief    : Avalon-MM master sequencing the interval timer (program, start,
//            service timeouts, snapshot read-back, stop) without CPU help.
// Revision : 1.0 - initial release
// ============================================================================
module timer_seq_master #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_TO, S_CLR_WAIT,
    S_STOP_WR, S_SNAP_WR, S_SNAP_RD_L, S_SNAP_RD_H, S_SNAP_CAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_period;
  logic                r_cont;
  logic                r_running;
  logic                r_busy;
  logic                r_tick;
  logic [TICK_W-1:0]   r_tick_count;
  logic [15:0]         r_snap_lo;
  logic [31:0]         r_snap_value;
  logic                r_snap_valid;
  logic [2:0]          r_addr;
  logic                r_cs;
  logic                r_wn;
  logic [15:0]         r_wd;
  logic                w_cs;
  logic                w_wn;
  logic [2:0]          w_addr;
  logic [15:0]         w_wd;

  // Bus signals are decoded from the next state so the registered outputs
  // line up with the state register.
  always_comb begin
    w_next = r_state;
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = 3'd0;
    w_wd   = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (cfg_start)     w_next = S_WR_PL;
        else if (stop_req) w_next = S_STOP_WR;
        else if (snap_req) w_next = S_SNAP_WR;
      end
      S_WR_PL:     w_next = S_WR_PH;
      S_WR_PH:     w_next = S_WR_CTRL;
      S_WR_CTRL:   w_next = S_RUN;
      S_RUN: begin
        if (timer_irq)     w_next = S_CLR_TO;
        else if (stop_req) w_next = S_STOP_WR;
        else if (snap_req) w_next = S_SNAP_WR;
      end
      S_CLR_TO:    w_next = S_CLR_WAIT;
      S_CLR_WAIT:  w_next = r_cont ? S_RUN : S_IDLE;
      S_STOP_WR:   w_next = S_IDLE;
      S_SNAP_WR:   w_next = S_SNAP_RD_L;
      S_SNAP_RD_L: w_next = S_SNAP_RD_H;
      S_SNAP_RD_H: w_next = S_SNAP_CAP;
      S_SNAP_CAP:  w_next = r_running ? S_RUN : S_IDLE;
      default:     w_next = S_IDLE;
    endcase

    case (w_next)
      S_WR_PL:     begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wd = cfg_period[15:0]; end
      S_WR_PH:     begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wd = r_period[31:16]; end
      S_WR_CTRL:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wd = r_cont ? 16'h0007 : 16'h0005; end
      S_CLR_TO:    begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0; end
      S_STOP_WR:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wd = 16'h0008; end
      S_SNAP_WR:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd4; end
      S_SNAP_RD_L: begin w_cs = 1'b1; w_addr = 3'd4; end
      S_SNAP_RD_H: begin w_cs = 1'b1; w_addr = 3'd5; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_period     <= 32'h0;
      r_cont       <= 1'b0;
      r_running    <= 1'b0;
      r_busy       <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_snap_lo    <= 16'h0;
      r_snap_value <= 32'h0;
      r_snap_valid <= 1'b0;
      r_addr       <= 3'd0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_wd         <= 16'h0;
    end else begin
      r_state      <= w_next;
      r_addr       <= w_addr;
      r_cs         <= w_cs;
      r_wn         <= w_wn;
      r_wd         <= w_wd;
      r_busy       <= (w_next != S_IDLE);
      r_tick       <= (w_next == S_CLR_TO);
      r_snap_valid <= (r_state == S_SNAP_CAP);

      if (r_state == S_IDLE && cfg_start) begin
        r_period     <= cfg_period;
        r_cont       <= cfg_continuous;
        r_tick_count <= '0;
      end else if (w_next == S_CLR_TO) begin
        r_tick_count <= r_tick_count + TICK_W'(1);
      end

      if (r_state == S_WR_CTRL)
        r_running <= 1'b1;
      else if (r_state == S_STOP_WR || (r_state == S_CLR_WAIT && !r_cont))
        r_running <= 1'b0;

      // Read data lags the address by one cycle, hence the offset capture.
      if (r_state == S_SNAP_RD_H)
        r_snap_lo <= avm_readdata;
      if (r_state == S_SNAP_CAP)
        r_snap_value <= {avm_readdata, r_snap_lo};
    end
  end

  assign busy           = r_busy;
  assign running        = r_running;
  assign tick           = r_tick;
  assign tick_count     = r_tick_count;
  assign snap_value     = r_snap_value;
  assign snap_valid     = r_snap_valid;
  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_writedata  = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_timer_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_seq_master
// Brief    : Scoreboard bench for timer_seq_master with a small timer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_seq_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_period = 32'h0;
  logic        cfg_continuous = 1'b0;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        busy, running, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0;
  logic        timer_irq = 1'b0;
  logic        irq_req = 1'b0;

  typedef struct packed {
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        exp_q[$];
  logic [31:0] snap_q[$];
  bus_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          tick_seen = 0;
  int          snap_seen = 0;

  timer_seq_master #(.TICK_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timer model: registered read data, level irq cleared by a status write.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 3'd4) ? 16'h1234 :
                      (avm_address == 3'd5) ? 16'hABCD : 16'h0000;
    else
      avm_readdata <= 16'h0000;
    if (irq_req)
      timer_irq <= 1'b1;
    else if (avm_chipselect && !avm_write_n && avm_address == 3'd0)
      timer_irq <= 1'b0;
  end

  always @(negedge clk) begin
    if (tick) tick_seen++;
    if (snap_valid) begin
      snap_seen++;
      if (snap_q.size() == 0) chk("unexp_snap_valid", {31'b0, snap_valid}, 32'd0);
      else chk("snap_value", snap_value, snap_q.pop_front());
    end
    if (avm_chipselect) begin
      if (exp_q.size() == 0) begin
        chk("unexp_bus_cs", {31'b0, avm_chipselect}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bus_addr", {29'b0, avm_address}, {29'b0, e.addr});
        chk("bus_write_n", {31'b0, avm_write_n}, {31'b0, e.wn});
        if (!e.wn) chk("bus_wdata", {16'b0, avm_writedata}, {16'b0, e.data});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back('{wn: 1'b0, addr: a, data: d});
  endtask

  task automatic start_cfg(input logic [31:0] p, input logic c);
    @(posedge clk); #1;
    cfg_period = p; cfg_continuous = c; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic fire_irq();
    @(posedge clk); #1 irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0;
    cyc(5);
  endtask

  initial begin
    // Reset values
    cyc(3);
    @(negedge clk);
    chk("rst_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("rst_wn", {31'b0, avm_write_n}, 32'd1);
    chk("rst_addr", {29'b0, avm_address}, 32'd0);
    chk("rst_wdata", {16'b0, avm_writedata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_running", {31'b0, running}, 32'd0);
    chk("rst_tick_count", {16'b0, tick_count}, 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cyc(2);

    // Continuous start: three consecutive writes, running after control write
    push_wr(3'd2, 16'h86A0); push_wr(3'd3, 16'h0001); push_wr(3'd1, 16'h0007);
    start_cfg(32'h0001_86A0, 1'b1);
    @(negedge clk); chk("start_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk); chk("run_before_ctrl", {31'b0, running}, 32'd0);
    @(negedge clk);
    chk("run_after_ctrl", {31'b0, running}, 32'd1);
    chk("start_q_empty", exp_q.size(), 32'd0);
    chk("run_idle_bus", {31'b0, avm_chipselect}, 32'd0);

    // Three timeouts serviced
    for (int i = 0; i < 3; i++) begin
      push_wr(3'd0, 16'h0000);
      fire_irq();
    end
    chk("ticks3_count", {16'b0, tick_count}, 32'd3);
    chk("ticks3_seen", tick_seen, 32'd3);

    // cfg_start in RUN must be ignored
    start_cfg(32'hDEAD_BEEF, 1'b0);
    cyc(4);
    chk("ign_tick_count", {16'b0, tick_count}, 32'd3);
    chk("ign_running", {31'b0, running}, 32'd1);

    // Snapshot read-back
    push_wr(3'd4, 16'h0000);
    exp_q.push_back('{wn: 1'b1, addr: 3'd4, data: 16'h0});
    exp_q.push_back('{wn: 1'b1, addr: 3'd5, data: 16'h0});
    snap_q.push_back(32'hABCD_1234);
    @(posedge clk); #1 snap_req = 1'b1;
    @(posedge clk); #1 snap_req = 1'b0;
    cyc(8);
    chk("snap_pulses", snap_seen, 32'd1);
    chk("snap_hold", snap_value, 32'hABCD_1234);
    chk("snap_back_run", {30'b0, busy, running}, 32'd3);

    // irq coincident with stop and snap: only the status clear happens
    push_wr(3'd0, 16'h0000);
    @(posedge clk); #1 irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0; stop_req = 1'b1; snap_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0; snap_req = 1'b0;
    cyc(6);
    chk("coinc_tick_count", {16'b0, tick_count}, 32'd4);
    chk("coinc_running", {31'b0, running}, 32'd1);
    chk("coinc_q_empty", exp_q.size(), 32'd0);

    // Stop from RUN
    push_wr(3'd1, 16'h0008);
    @(posedge clk); #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    cyc(3);
    chk("stop_running", {31'b0, running}, 32'd0);
    chk("stop_busy", {31'b0, busy}, 32'd0);

    // One-shot start and single timeout
    push_wr(3'd2, 16'h0010); push_wr(3'd3, 16'h0000); push_wr(3'd1, 16'h0005);
    start_cfg(32'h0000_0010, 1'b0);
    cyc(4);
    chk("os_tick_clear", {16'b0, tick_count}, 32'd0);
    chk("os_running", {31'b0, running}, 32'd1);
    push_wr(3'd0, 16'h0000);
    fire_irq();
    chk("os_done_running", {31'b0, running}, 32'd0);
    chk("os_done_busy", {31'b0, busy}, 32'd0);
    chk("os_tick_count", {16'b0, tick_count}, 32'd1);
    cyc(10);
    chk("os_q_empty", exp_q.size(), 32'd0);

    // Reset during WR_PH: no control write afterwards
    push_wr(3'd2, 16'h0055); push_wr(3'd3, 16'h0000);
    start_cfg(32'h0000_0055, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("mid_rst_wn", {31'b0, avm_write_n}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_tick_count", {16'b0, tick_count}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cyc(10);
    chk("mid_rst_q_empty", exp_q.size(), 32'd0);
    chk("mid_rst_idle", {31'b0, busy}, 32'd0);
    chk("total_ticks", tick_seen, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_seq_master.md
Name: timer_seq_master

Overview:
- Avalon-MM master that drives the 16-bit register interface of the interval timer peripheral, so timer use needs no CPU.
- Programs period and control, starts the timer and services its irq (clears status, counts ticks).
- On request, takes a counter snapshot and reads it back as a 32-bit value, or stops the timer.
- Sits beside the timer in the SOPC fabric; its bus outputs connect directly to the timer slave port.

Parameters:
- TICK_W, 16, width of the timeout event counter tick_count.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse: load cfg_period and cfg_continuous, then start the timer.
- cfg_period  in  32  period value written to period_l (bits 15:0) and period_h (bits 31:16).
- cfg_continuous  in  1  1 = continuous mode, 0 = one-shot.
- stop_req  in  1  one-cycle pulse: stop the timer.
- snap_req  in  1  one-cycle pulse: snapshot and read the counter.
- busy  out  1  1 in every state except IDLE.
- running  out  1  1 from the control write until stop, or until a one-shot timeout has been cleared.
- tick  out  1  one-cycle pulse for each serviced timeout.
- tick_count  out  TICK_W  serviced timeouts since the last accepted cfg_start; wraps.
- snap_value  out  32  last snapshot value read.
- snap_valid  out  1  one-cycle pulse when snap_value updates.
- avm_address  out  3  timer register index (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h).
- avm_chipselect  out  1  bus cycle active.
- avm_write_n  out  1  0 = write, 1 = read.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  timer read data; valid one cycle after the address is presented.
- timer_irq  in  1  timer interrupt; level, held until status is written.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0; busy=0, running=0, tick=0, snap_valid=0; tick_count=0, snap_value=0.
- Reset mid-operation abandons the sequence the next cycle with no further bus cycles. The timer itself is not stopped.
- Each bus state drives exactly one single-cycle access; there is no waitrequest. Outside bus states, chipselect=0 and write_n=1.
- IDLE:
  - cfg_start -> latch period and mode, clear tick_count, go to WR_PL.
  - stop_req -> STOP_WR.
  - snap_req -> SNAP_WR.
  - Priority: cfg_start > stop_req > snap_req.
- Start sequence:
  - WR_PL: write addr 2 = period[15:0].
  - WR_PH: write addr 3 = period[31:16].
  - WR_CTRL: write addr 1 = 0x0005 (START, ITO) or 0x0007 (START, CONT, ITO) when continuous; running<=1.
  - Then go to RUN.
- RUN (busy=1, no bus cycle); priority timer_irq > stop_req > snap_req; cfg_start is ignored.
- Timeout service:
  - CLR_TO: write addr 0 = 0x0000; tick pulses; tick_count<=tick_count+1 (mod 2^TICK_W).
  - CLR_WAIT: one idle cycle so the timer's irq deassertion is seen.
  - Then RUN if continuous. If one-shot: running<=0 and go to IDLE.
- Stop: STOP_WR writes addr 1 = 0x0008; running<=0; go to IDLE.
- Snapshot:
  - SNAP_WR: write addr 4 = 0x0000.
  - SNAP_RD_L: read addr 4.
  - SNAP_RD_H: read addr 5; capture readdata as low half.
  - SNAP_CAP: capture readdata as high half; snap_valid pulses with snap_value updated the same cycle.
  - Return to RUN if running, else IDLE.
- Request handling: a stop_req or snap_req arriving while not in IDLE/RUN is dropped. A timer_irq arriving during a snapshot is serviced on return to RUN (level input, not lost).
- cfg_period=0 is written as-is; no special handling.

Test Plan:
- Reset, then cfg_start with period=0x0001_86A0, continuous=1 -> writes (2,0x86A0), (3,0x0001), (1,0x0007) on 3 consecutive cycles; running=1 the cycle after the control write.
- Continuous run, timer_irq asserted 3 times -> three writes (0,0x0000), tick pulses 3 times, tick_count=3; cfg_start issued in RUN is ignored.
- One-shot start, period=0x0000_0010, then one irq -> control write 0x0005, status clear, running=0, busy=0, no further bus cycles.
- snap_req in RUN with a model returning 0x1234 (addr 4) and 0xABCD (addr 5) -> write addr 4, read 4, read 5; snap_value=0xABCD1234 with snap_valid for 1 cycle; back in RUN.
- stop_req in RUN -> write (1,0x0008), running=0, IDLE. stop_req and snap_req in the same cycle as timer_irq -> status clear first, both requests dropped.
- Reset asserted during WR_PH -> next cycle chipselect=0, write_n=1, state IDLE, tick_count=0, no WR_CTRL write issued.
